// File: rtl/registers.sv
// 16 x 16-bit register file on a shared bidirectional data bus, byte-lane writable.
// Latency: reads are combinational; writes land on the rising clk edge.
// Backpressure: none; every enabled access completes in the cycle it is presented.
module registers #(
  parameter int ADDR_BUS_WIDTH = 8,
  parameter int DATA_BUS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [1:0]                be,
  input  logic [ADDR_BUS_WIDTH-1:0] addr,
  inout  wire  [DATA_BUS_WIDTH-1:0] data
);

  localparam int NUM_REGS = 16;

  logic [DATA_BUS_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_BUS_WIDTH-1:0] regs_d [NUM_REGS];

  logic                      addr_hit;
  logic                      wr_go;
  logic                      rd_oe;
  logic [3:0]                idx;
  logic [DATA_BUS_WIDTH-1:0] rd_dat;

  // Only the low 16 word addresses map onto the file; anything above is a hole.
  assign addr_hit = ((addr >> 4) == '0);
  assign idx      = addr[3:0];

  // Writes need the full enable set and an in-range address; be picks the lanes.
  assign wr_go = en & wr & addr_hit;

  // The bus is driven only for a clean read; rd with wr means the host owns the bus.
  assign rd_oe = en & rd & ~wr;

  // Read mux: holes read as zero, whole word regardless of byte enables.
  always_comb begin
    rd_dat = '0;
    if (addr_hit) begin
      rd_dat = regs_q[idx];
    end
  end

  assign data = rd_oe ? rd_dat : {DATA_BUS_WIDTH{1'bz}};

  // Next-state: merge the enabled byte lanes from the bus into the addressed word.
  always_comb begin
    regs_d = regs_q;
    if (wr_go) begin
      if (be[0]) begin
        regs_d[idx][7:0] = data[7:0];
      end
      if (be[1]) begin
        regs_d[idx][15:8] = data[15:8];
      end
    end
  end

  // State update; reset wins over a same-edge write, which is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_registers.sv
module tb_registers;

  logic        clk;
  logic        reset;
  logic        en;
  logic        rd;
  logic        wr;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic        tb_oe;
  logic [15:0] tb_val;
  wire  [15:0] data;

  int checks;
  int failures;

  localparam logic [15:0] PROBE = 16'hA5A5;

  assign data = tb_oe ? tb_val : 16'hzzzz;

  registers #(.ADDR_BUS_WIDTH(8), .DATA_BUS_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .rd    (rd),
    .wr    (wr),
    .be    (be),
    .addr  (addr),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] dat;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; rd = 1'b0; wr = 1'b0; be = 2'b00; tb_oe = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [1:0] b, input logic [15:0] v);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; rd = 1'b0; be = b; addr = a; tb_oe = 1'b1; tb_val = v;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [15:0] exp, input string name);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; wr = 1'b0; be = 2'b00; addr = a; tb_oe = 1'b0;
    #1;
    check(name, data, exp);
    idle();
  endtask

  // With the block silent the bus carries exactly the bench probe pattern.
  task automatic hiz_chk(input string name);
    tb_oe = 1'b1; tb_val = PROBE;
    #1;
    check(name, data, PROBE);
    tb_oe = 1'b0;
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].be, vecs[i].dat);
      else               read_chk(vecs[i].addr, vecs[i].dat, vecs[i].name);
    end
    vecs.delete();
  endtask

  function automatic vec_t W(input logic [7:0] a, input logic [1:0] b, input logic [15:0] v);
    vec_t t;
    t.is_wr = 1'b1; t.be = b; t.addr = a; t.dat = v; t.name = "wr";
    return t;
  endfunction

  function automatic vec_t R(input logic [7:0] a, input logic [15:0] exp, input string n);
    vec_t t;
    t.is_wr = 1'b0; t.be = 2'b00; t.addr = a; t.dat = exp;
    t.name = $sformatf("%s_w%0d", n, a);
    return t;
  endfunction

  initial begin
    logic [7:0] rst_words [8];
    checks = 0; failures = 0;
    reset = 1'b1; addr = 8'd0; tb_val = 16'h0000;
    idle();

    // Reset held two edges; a read while still in reset shows the cleared word.
    @(posedge clk);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; addr = 8'd3;
    #1;
    check("read_during_reset", data, 16'h0000);
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset reads with the bus released between them.
    rst_words = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd9, 8'd12, 8'd13};
    foreach (rst_words[i]) begin
      read_chk(rst_words[i], 16'h0000, $sformatf("reset_w%0d", rst_words[i]));
      hiz_chk($sformatf("hiz_after_w%0d", rst_words[i]));
    end

    // Full-word writes and readback.
    vecs.push_back(W(8'd0,  2'b11, 16'hDEAD));
    vecs.push_back(W(8'd1,  2'b11, 16'hBEEF));
    vecs.push_back(W(8'd2,  2'b11, 16'hCAFE));
    vecs.push_back(W(8'd4,  2'b11, 16'hFACE));
    vecs.push_back(W(8'd8,  2'b11, 16'hBEAD));
    vecs.push_back(W(8'd9,  2'b11, 16'hFADE));
    vecs.push_back(W(8'd12, 2'b11, 16'hDEAF));
    vecs.push_back(W(8'd13, 2'b11, 16'hFACE));
    vecs.push_back(W(8'd14, 2'b11, 16'hFACE));
    vecs.push_back(W(8'd15, 2'b11, 16'hFACE));
    vecs.push_back(R(8'd0,  16'hDEAD, "full"));
    vecs.push_back(R(8'd1,  16'hBEEF, "full"));
    vecs.push_back(R(8'd2,  16'hCAFE, "full"));
    vecs.push_back(R(8'd3,  16'h0000, "full"));
    vecs.push_back(R(8'd4,  16'hFACE, "full"));
    vecs.push_back(R(8'd8,  16'hBEAD, "full"));
    vecs.push_back(R(8'd9,  16'hFADE, "full"));
    vecs.push_back(R(8'd12, 16'hDEAF, "full"));
    vecs.push_back(R(8'd13, 16'hFACE, "full"));
    vecs.push_back(R(8'd14, 16'hFACE, "full"));
    vecs.push_back(R(8'd15, 16'hFACE, "full"));
    apply_vecs();

    // Byte lanes: low lane cleared, high lane set -> 0xFF00 for words 0..14.
    for (int w = 0; w < 15; w++) begin
      vecs.push_back(W(8'(w), 2'b01, 16'h0000));
      vecs.push_back(W(8'(w), 2'b10, 16'hFFFF));
    end
    for (int w = 0; w < 15; w++) vecs.push_back(R(8'(w), 16'hFF00, "lanes"));
    vecs.push_back(R(8'd15, 16'hFACE, "lanes"));
    apply_vecs();

    // Out-of-range write is a no-op and the hole reads zero.
    vecs.push_back(W(8'd16, 2'b11, 16'h1234));
    vecs.push_back(R(8'd16, 16'h0000, "oor"));
    for (int w = 0; w < 15; w++) vecs.push_back(R(8'(w), 16'hFF00, "oor"));
    vecs.push_back(R(8'd15, 16'hFACE, "oor"));
    apply_vecs();

    // Write with en low is ignored.
    @(negedge clk);
    en = 1'b0; wr = 1'b1; be = 2'b11; addr = 8'd0; tb_oe = 1'b1; tb_val = 16'h5555;
    @(posedge clk);
    #1;
    idle();
    read_chk(8'd0, 16'hFF00, "en0_write");

    // be=00 write is ignored.
    do_write(8'd2, 2'b00, 16'h1234);
    read_chk(8'd2, 16'hFF00, "be00_write");

    // Reset beats a simultaneous write.
    @(negedge clk);
    reset = 1'b1; en = 1'b1; wr = 1'b1; be = 2'b11; addr = 8'd1; tb_oe = 1'b1; tb_val = 16'h7777;
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    read_chk(8'd1, 16'h0000, "reset_vs_write_w1");
    read_chk(8'd15, 16'h0000, "reset_clears_w15");

    // Partial-lane merges.
    do_write(8'd6, 2'b01, 16'h99AB);
    read_chk(8'd6, 16'h00AB, "lane_lo");
    do_write(8'd6, 2'b10, 16'hCD11);
    read_chk(8'd6, 16'hCDAB, "lane_hi");

    // rd+wr together: bench owns the bus, write still lands.
    do_write(8'd5, 2'b11, 16'h2468);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; wr = 1'b1; be = 2'b11; addr = 8'd5; tb_oe = 1'b1; tb_val = 16'h0F0F;
    #1;
    check("rdwr_bus_not_driven", data, 16'h0F0F);
    @(posedge clk);
    #1;
    idle();
    read_chk(8'd5, 16'h0F0F, "rdwr_write_lands");

    // Combinational read follows addr with no clock edge, then releases.
    do_write(8'd7, 2'b11, 16'h1111);
    do_write(8'd8, 2'b11, 16'h2222);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; wr = 1'b0; addr = 8'd7;
    #1;
    check("comb_addr7", data, 16'h1111);
    addr = 8'd8;
    #1;
    check("comb_addr8", data, 16'h2222);
    addr = 8'd6;
    #1;
    check("comb_addr6", data, 16'hCDAB);
    rd = 1'b0;
    hiz_chk("hiz_rd_dropped");
    rd = 1'b1; en = 1'b0;
    hiz_chk("hiz_en_low");
    idle();

    // Contents persist across idle cycles; reads leave no trace.
    repeat (5) @(posedge clk);
    read_chk(8'd8, 16'h2222, "persist_w8");
    read_chk(8'd8, 16'h2222, "reread_w8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameter ADDR_BUS_WIDTH, default 8, width of the word address bus.
REQ-002 Parameter DATA_BUS_WIDTH, default 16, width of the data bus; SHALL be 16 (two byte lanes).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  access enable; no read or write without en=1.
REQ-006 rd  input  1  read enable.
REQ-007 wr  input  1  write enable.
REQ-008 be  input  2  byte enables; be[0]=low byte data[7:0], be[1]=high byte data[15:8].
REQ-009 addr  input  ADDR_BUS_WIDTH  word address (host byte address >> 1).
REQ-010 data  inout  DATA_BUS_WIDTH  bidirectional data bus; driven by the block only during reads.

Function
REQ-011 The block SHALL contain a file of 16 registers, 16 bits each, selected by addr[3:0] when addr < 16.
REQ-012 Write: at a rising clk edge with en=1, wr=1, reset=0 and addr < 16, each byte lane with its be bit set SHALL load from data; lanes with be bit clear SHALL hold.
REQ-013 Writes with addr >= 16, en=0, or be=00 SHALL change no register.
REQ-014 Read: while en=1, rd=1 and wr=0, data SHALL be driven combinationally with the addressed register (no clock latency); addr >= 16 SHALL read 0x0000.
REQ-015 Read data SHALL be the full 16-bit word regardless of be.
REQ-016 When en=0, rd=0, or wr=1, data SHALL be high-impedance on all bits.
REQ-017 rd=1 and wr=1 together with en=1: the write SHALL occur and the bus SHALL not be driven.
REQ-018 A write and a read of the same register on consecutive accesses SHALL return the newly written value; a read during the write cycle SHALL show the old value until the clock edge.
REQ-019 Register contents SHALL persist indefinitely between accesses; read SHALL have no side effects.

Reset
REQ-020 At a rising clk edge with reset=1, all 16 registers SHALL become 0x0000.
REQ-021 reset SHALL take priority over a simultaneous write; that write is discarded.
REQ-022 Bus output enable SHALL depend only on en/rd/wr, so reads during reset SHALL return current register contents (0x0000 after the first reset edge).

Verification
REQ-023 Pulse reset, then read words 0,1,2,4,8,9,12,13 -> each 0x0000; data high-Z between reads.
REQ-024 Write be=11: word0=0xDEAD, word1=0xBEEF, word2=0xCAFE, word4=0xFACE, word8=0xBEAD, word9=0xFADE, word12=0xDEAF, word13..15=0xFACE -> read back identical values; word 3 still 0x0000.
REQ-025 For words 0..14: write be=01 data 0x0000, then be=10 data 0xFFFF -> each reads 0xFF00; word 15 keeps 0xFACE.
REQ-026 Write addr=16 (be=11, 0x1234) -> read addr 16 gives 0x0000 and words 0..15 unchanged.
REQ-027 Assert wr with en=0 (word0, 0x5555) -> word0 unchanged; assert reset during a write to word1 -> word1 reads 0x0000.
REQ-028 With en=1, rd=1, wr=0, change addr without a clock edge -> data follows the new register immediately; drop rd -> data returns to high-Z.
